// File: rtl/bus_arbiter_4x16.sv
// Round-robin arbiter sharing one 16-bit result bus between four requesters.
// A hold limit bounds each tenure, and one idle cycle always separates two owners.
module bus_arbiter_4x16 #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [3:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  output logic [3:0]  gnt,
  output logic [1:0]  sel,
  output logic [15:0] bus_value,
  output logic        bus_valid
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit               LIMITED   = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = LIMITED ? CNT_W'(MAX_HOLD - 1) : '0;

  state_t           state;
  logic [1:0]       rr_ptr;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       rot;
  logic [1:0]       offset;
  logic [1:0]       winner;
  logic             release_now;
  logic [15:0]      mux_out;

  // Rotate req so that bit 0 is the rr_ptr requester, then take the first set bit.
  assign rot = 4'({req, req} >> rr_ptr);

  // NOTE: every signal assigned in always_comb gets a default first, so no latch can be inferred.
  always_comb begin
    offset = 2'd0;
    casez (rot)
      4'b???1: offset = 2'd0;
      4'b??10: offset = 2'd1;
      4'b?100: offset = 2'd2;
      default: offset = 2'd3;
    endcase
  end

  assign winner      = rr_ptr + offset;
  assign release_now = !req[sel] || (LIMITED && (hold_cnt == HOLD_LAST));

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      rr_ptr   <= 2'd0;
      hold_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            state    <= GRANT;
            gnt      <= 4'b0001 << winner;
            sel      <= winner;
            hold_cnt <= '0;
          end
        end
        GRANT: begin
          if (release_now) begin
            // sel is left alone so the mux select stays stable through the idle cycle.
            state  <= IDLE;
            gnt    <= 4'b0000;
            rr_ptr <= sel + 2'd1;
          end else if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus_valid = |gnt;

  always_comb begin
    mux_out = data0;
    case (sel)
      2'd0: mux_out = data0;
      2'd1: mux_out = data1;
      2'd2: mux_out = data2;
      2'd3: mux_out = data3;
      default: mux_out = data0;
    endcase
  end

  assign bus_value = bus_valid ? mux_out : 16'h0000;

endmodule

// File: tb/tb_bus_arbiter_4x16.sv
// Directed bench for bus_arbiter_4x16: one instance with a hold limit of 4,
// one unlimited instance, both sharing the same stimulus.
module tb_bus_arbiter_4x16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] dv [4];

  logic [3:0]  gnt_a,   gnt_b;
  logic [1:0]  sel_a,   sel_b;
  logic [15:0] value_a, value_b;
  logic        valid_a, valid_b;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  bus_arbiter_4x16 #(.MAX_HOLD(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req),
    .data0(dv[0]), .data1(dv[1]), .data2(dv[2]), .data3(dv[3]),
    .gnt(gnt_a), .sel(sel_a), .bus_value(value_a), .bus_valid(valid_a)
  );

  bus_arbiter_4x16 #(.MAX_HOLD(0), .CNT_W(8)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req),
    .data0(dv[0]), .data1(dv[1]), .data2(dv[2]), .data3(dv[3]),
    .gnt(gnt_b), .sel(sel_b), .bus_value(value_b), .bus_valid(valid_b)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req     = 4'b0000;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    logic [3:0]  exp_gnt;
    logic [1:0]  owner;
    logic [1:0]  last_owner;

    dv[0] = 16'h0A0A; dv[1] = 16'h1B1B; dv[2] = 16'h2C2C; dv[3] = 16'h3D3D;
    step(2);
    check("por_gnt",   16'(gnt_a),   16'h0);
    check("por_valid", 16'(valid_a), 16'h0);
    check("por_value", value_a,      16'h0);
    reset_n = 1'b1;

    // Mid-run asynchronous reset while a grant is active.
    req = 4'b1111;
    step(2);
    check("pre_rst_gnt", 16'(gnt_a), 16'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_gnt",   16'(gnt_a),   16'h0);
    check("rst_sel",   16'(sel_a),   16'h0);
    check("rst_valid", 16'(valid_a), 16'h0);
    check("rst_value", value_a,      16'h0);
    @(negedge clk);
    req = 4'b0000;
    reset_n = 1'b1;
    step(1);
    check("rst_idle_gnt", 16'(gnt_a), 16'h0);

    // Single request, one-cycle tenure.
    req = 4'b0010; dv[1] = 16'hACAC;
    step(1);
    check("t2_gnt",   16'(gnt_a),   16'h2);
    check("t2_sel",   16'(sel_a),   16'h1);
    check("t2_value", value_a,      16'hACAC);
    check("t2_valid", 16'(valid_a), 16'h1);
    req = 4'b0000;
    step(1);
    check("t2_rel_gnt",   16'(gnt_a),   16'h0);
    check("t2_rel_valid", 16'(valid_a), 16'h0);
    check("t2_rel_value", value_a,      16'h0);
    check("t2_rel_sel",   16'(sel_a),   16'h1);

    // All four requesting: four-cycle tenures in rotation, one idle cycle between.
    do_reset();
    dv[0] = 16'h1000; dv[1] = 16'h1111; dv[2] = 16'h2222; dv[3] = 16'h3333;
    req = 4'b1111;
    last_owner = 2'd0;
    for (int c = 0; c < 25; c++) begin
      step(1);
      owner = 2'((c / 5) % 4);
      if ((c % 5) < 4) begin
        exp_gnt = 4'b0001 << owner;
        check($sformatf("rr_gnt_c%0d", c),   16'(gnt_a), 16'(exp_gnt));
        check($sformatf("rr_sel_c%0d", c),   16'(sel_a), 16'(owner));
        check($sformatf("rr_value_c%0d", c), value_a,    dv[owner]);
        last_owner = owner;
      end else begin
        check($sformatf("rr_idle_gnt_c%0d", c), 16'(gnt_a), 16'h0);
        check($sformatf("rr_idle_sel_c%0d", c), 16'(sel_a), 16'(last_owner));
        check($sformatf("rr_idle_val_c%0d", c), value_a,    16'h0);
      end
    end

    // Owner 2 forced out while req=0101: pointer moves to 3, wraps to 0.
    do_reset();
    req = 4'b0100;
    step(1);
    check("t4_first_gnt", 16'(gnt_a), 16'h4);
    req = 4'b0101;
    for (int c = 0; c < 3; c++) begin
      step(1);
      check($sformatf("t4_hold_c%0d", c), 16'(gnt_a), 16'h4);
    end
    step(1);
    check("t4_idle_gnt", 16'(gnt_a), 16'h0);
    step(1);
    check("t4_wrap_gnt", 16'(gnt_a), 16'h1);
    check("t4_wrap_sel", 16'(sel_a), 16'h0);

    // Unlimited hold: owner 0 keeps the bus well past counter saturation.
    do_reset();
    req = 4'b0001;
    for (int c = 0; c < 300; c++) begin
      step(1);
      check($sformatf("t5_gnt_c%0d", c),   16'(gnt_b),   16'h1);
      check($sformatf("t5_valid_c%0d", c), 16'(valid_b), 16'h1);
    end
    req = 4'b0000;
    step(1);
    check("t5_rel_gnt", 16'(gnt_b), 16'h0);

    // Owner data changes propagate combinationally; bus zeroes after release.
    do_reset();
    dv[3] = 16'h5554;
    req = 4'b1000;
    step(1);
    check("t6_gnt",    16'(gnt_a), 16'h8);
    check("t6_value0", value_a,    16'h5554);
    #1 dv[3] = 16'hAAAA;
    #1;
    check("t6_value1", value_a,    16'hAAAA);
    req = 4'b0000;
    step(1);
    check("t6_rel_value", value_a,    16'h0);
    check("t6_rel_sel",   16'(sel_a), 16'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fails);
    $finish;
  end

endmodule
